// File: rtl/day4_mask_writer.sv
// day4_mask_writer
// Producer side of the Day 4 result memory. A puzzle grid arrives as a
// row-major bit stream (1 = roll) and is held in an internal bit array.
// Every cell is then scanned once, and one 32-bit word per cell is written
// to the result RAM: 1 when the cell is a roll with fewer than four occupied
// 8-neighbours, otherwise 0. The running sum of those words is kept in
// `total` so the downstream accumulator can be cross-checked.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_valid  a grid cell is present on in_bit
//   in_bit    cell value, 1 = roll
//   in_ready  block accepts a cell this cycle (LOAD only)
//   wr_en     result RAM write strobe
//   wr_addr   result RAM address, row*COLS + col
//   wr_data   0x00000001 for an accessible roll, else 0
//   total     number of accessible rolls, final once done=1
//   done      scan complete, held until rst
module day4_mask_writer #(
    parameter int COLS   = 136,
    parameter int ROWS   = 136,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [31:0]       total,
    output logic              done
);

    localparam int CELLS = COLS * ROWS;
    // The bit array is padded to a power of two so the load index width
    // matches the array exactly; the padding cells are never read.
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {
        LOAD,
        SCAN,
        DONE
    } state_t;

    state_t              state;
    logic [DEPTH-1:0]    grid;
    logic [IDX_W-1:0]    load_idx;
    logic [ADDR_W-1:0]   scan_idx;
    logic [ADDR_W-1:0]   row;
    logic [ADDR_W-1:0]   col;
    logic [3:0]          n;
    logic                accessible;
    logic                accept;
    int                  rr;
    int                  cc;

    assign accept = (state == LOAD) && in_valid && in_ready;

    // Grid storage is deliberately not reset: each LOAD rewrites every cell.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            grid[load_idx] <= in_bit;
        end
    end

    // Neighbour count for the cell under the scan. The row/column counters
    // track the scan index so edge tests need no division; neighbours that
    // fall off any edge are skipped, which also prevents wrap-around between
    // the last column of one row and the first column of the next.
    always_comb begin
        n  = 4'd0;
        rr = 0;
        cc = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(row) + dr;
                cc = int'(col) + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < ROWS &&
                    cc >= 0 && cc < COLS) begin
                    n = n + {3'b000, grid[IDX_W'(rr * COLS + cc)]};
                end
            end
        end
        accessible = grid[IDX_W'(int'(row) * COLS + int'(col))] && (n < 4'd4);
    end

    // Control FSM with registered outputs. in_ready is a register so it is
    // low for the first cycle after reset and drops the cycle after the last
    // cell is taken. Each SCAN edge issues one write for scan_idx.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            in_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
            total    <= 32'd0;
            done     <= 1'b0;
            load_idx <= '0;
            scan_idx <= '0;
            row      <= '0;
            col      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    wr_en    <= 1'b0;
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (load_idx == IDX_W'(CELLS - 1)) begin
                            state    <= SCAN;
                            in_ready <= 1'b0;
                        end else begin
                            load_idx <= load_idx + IDX_W'(1);
                        end
                    end
                end
                SCAN: begin
                    in_ready <= 1'b0;
                    wr_en    <= 1'b1;
                    wr_addr  <= scan_idx;
                    wr_data  <= {31'd0, accessible};
                    total    <= total + {31'd0, accessible};
                    scan_idx <= scan_idx + ADDR_W'(1);
                    if (col == ADDR_W'(COLS - 1)) begin
                        col <= '0;
                        row <= row + ADDR_W'(1);
                    end else begin
                        col <= col + ADDR_W'(1);
                    end
                    if (scan_idx == ADDR_W'(CELLS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    wr_en    <= 1'b0;
                    done     <= 1'b1;
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/day4_mask_writer.md
# day4_mask_writer

Producer side of the Day 4 result memory. The block accepts the puzzle grid as a row-major bit stream, one cell per handshake (1 = roll, 0 = empty), and stores it in an internal bit array. It then scans every cell and writes one 32-bit word per cell into the downstream result RAM: 1 if the cell holds a roll with fewer than 4 occupied 8-neighbours, else 0. The downstream accumulator sums these words to produce the Part 1 answer. The block also reports that sum directly for cross-checking.

## Interface
- COLS, default 136, grid width in cells (≥1)
- ROWS, default 136, grid height in cells (≥1)
- ADDR_W, default 15, write address width; COLS*ROWS ≤ 2^ADDR_W
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  grid cell present
- in_bit  in  1  cell value, 1 = roll
- in_ready  out  1  block accepts a cell this cycle
- wr_en  out  1  write strobe to result RAM
- wr_addr  out  ADDR_W  write address = row*COLS + col
- wr_data  out  32  0x00000001 for accessible roll, else 0x00000000
- total  out  32  count of accessible rolls, valid when done=1
- done  out  1  scan complete; held until rst

## Operation
- States: LOAD → SCAN → DONE. After rst the block is in LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, in_bit is stored at load index L (row-major), and L increments.
  - Accepting the cell at L=COLS*ROWS-1 moves the state to SCAN; in_ready is 0 from the next cycle.
  - in_valid gaps are allowed, with no timeout.
- SCAN:
  - Scan index S runs 0..COLS*ROWS-1, one cell per cycle, with no stalls.
  - For cell (r,c), n = sum of the 8 neighbours.
  - Positions outside 0..ROWS-1 / 0..COLS-1 count as 0; there is no wrap-around across row edges or grid edges.
  - n is 4 bits (max 8).
  - The cell is accessible iff cell=1 and n<4.
  - Registered outputs: wr_en=1, wr_addr=S, wr_data={31'b0, accessible}.
  - total increments by accessible for each cell. total is 32-bit and does not saturate (it cannot overflow within bounds).
  - After issuing S=COLS*ROWS-1 the state moves to DONE.
- DONE:
  - wr_en=0, in_ready=0, done=1, total frozen.
  - Further in_valid is ignored.
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, total=0, done=0. L=S=0, state=LOAD.
  - in_ready rises the cycle after rst deasserts.
  - Bit-array contents are not cleared; the next LOAD overwrites every cell.
- rst asserted in any state (including mid-LOAD or mid-SCAN):
  - Aborts the current operation on the next edge.
  - No further writes occur.
  - Partial RAM contents are not the block's responsibility.
- Grid of 1×1: one write, and a lone roll is accessible (n=0).

## Timing
- Cell accepted at edge k is visible to the scan from edge k+1.
- Last cell accepted at edge E: SCAN is entered at E.
  - The write for address a is presented (wr_en=1) during cycle E+1+a and captured by the RAM at edge E+2+a.
  - Exactly COLS*ROWS consecutive wr_en cycles, with addresses strictly ascending by 1.
- done=1 and the final total are visible in the cycle after the last wr_en cycle. wr_en=0 from that cycle.
- Input throughput: 1 cell/cycle. Total latency from first accept (no gaps) to done = COLS*ROWS + COLS*ROWS + 1 cycles.

## Test plan
- COLS=ROWS=3, all 1s, in_valid continuous:
  - Writes addr0..8 = 1,0,1,0,0,0,1,0,1 on 9 consecutive cycles.
  - total=4, done=1 one cycle after the last write.
- COLS=ROWS=3, all 0s:
  - Nine writes, all data 0, total=0.
- COLS=ROWS=3, only the centre=1:
  - Only addr4 data=1; total=1.
- AoC example 10×10 grid, with in_valid deasserted on random cycles:
  - in_ready=1 throughout LOAD, exactly 100 writes, total=13.
  - Per-address data matches the reference model.
- Edge isolation: COLS=4, ROWS=2, row0=0001, row1=1000:
  - Cells (0,3) and (1,0) are not neighbours.
  - addr3=1, addr4=1, all other addresses 0, total=2.
- Reset mid-SCAN: COLS=ROWS=3 all 1s, rst asserted during the write of addr4:
  - wr_en=0 and done=0 next cycle; total=0; in_ready=1 after release.
  - Reloading all 0s then yields total=0 and nine zero writes.
